// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace buffer: capture modes, FSM states and the
// entry layout helpers used to pack {cycle, reg, data} into one storage word.
package trace_pkg;

  typedef enum logic {
    STOP = 1'b0,
    WRAP = 1'b1
  } mode_e;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_e;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  // Entry layout, MSB to LSB: cycle stamp, register index, writeback data.
  function automatic int unsigned entry_width(input int unsigned cycle_w,
                                              input int unsigned reg_w,
                                              input int unsigned data_w);
    return cycle_w + reg_w + data_w;
  endfunction

  function automatic int unsigned reg_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned cycle_lsb(input int unsigned reg_w,
                                            input int unsigned data_w);
    return reg_w + data_w;
  endfunction

endpackage

// File: rtl/trace_ring.sv
// Circular entry store with push, pop and an overwrite that advances both pointers.
// Writes land on the next edge; the head word is read combinationally from storage.
module trace_ring #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             overwrite_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;
  logic             rd_adv;

  // Overwrite is a write onto the oldest slot, so it moves both pointers.
  assign wr_en  = push_i | overwrite_i;
  assign rd_adv = pop_i | overwrite_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_adv) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_en && !rd_adv) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_en && rd_adv) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures register-file writebacks with a cycle stamp during a fixed window; one-cycle capture
// latency, valid/ready drain whose head holds while out_ready=0; when full, STOP drops, WRAP overwrites.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_W       = 5,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CYCLE_W     = 32,
  parameter int unsigned CYCLE_LIMIT = 1000,
  parameter mode_e       MODE        = STOP
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wb_enable,
  input  logic [REG_W-1:0]         wb_reg,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CYCLE_W-1:0]       out_cycle,
  output logic [REG_W-1:0]         out_reg,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              dropped,
  output logic                     done
);

  localparam int unsigned ENTRY_W = entry_width(CYCLE_W, REG_W, DATA_W);
  localparam int unsigned REG_LSB = reg_lsb(DATA_W);
  localparam int unsigned CYC_LSB = cycle_lsb(REG_W, DATA_W);
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'(CYCLE_LIMIT - 1);

  state_e             state_q;
  logic               done_q;
  logic [CYCLE_W-1:0] cycle_q;
  logic               overflow_q, overflow_d;
  logic [15:0]        dropped_q, dropped_d;

  logic               capture;
  logic               pop;
  logic               lost_event;
  logic               push;
  logic               overwrite;
  logic               ring_full;
  logic               ring_empty;
  logic [CNT_W-1:0]   ring_count;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  assign capture    = wb_enable && (wb_reg != '0) && (state_q == RUN);
  assign pop        = !ring_empty && out_ready;
  // A pop in the same cycle always frees room, so only full-without-pop loses an event.
  assign lost_event = capture && ring_full && !pop;
  assign push       = capture && !lost_event;
  assign overwrite  = lost_event && (MODE == WRAP);

  assign wr_entry[CYC_LSB +: CYCLE_W] = cycle_q;
  assign wr_entry[REG_LSB +: REG_W]   = wb_reg;
  assign wr_entry[0 +: DATA_W]        = wb_data;

  trace_ring #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_ring (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .overwrite_i (overwrite),
    .wdata_i     (wr_entry),
    .rdata_o     (rd_entry),
    .count_o     (ring_count),
    .full_o      (ring_full),
    .empty_o     (ring_empty)
  );

  // Window FSM: the counter freezes once the window closes; only reset reopens it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      done_q  <= 1'b0;
      cycle_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          cycle_q <= cycle_q + CYCLE_W'(1);
          if (cycle_q == LAST_CYCLE) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= RUN;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    dropped_d  = dropped_q;
    if (lost_event) begin
      overflow_d = 1'b1;
      if (dropped_q != DROP_MAX) begin
        dropped_d = dropped_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end

  assign out_valid = !ring_empty;
  assign out_cycle = rd_entry[CYC_LSB +: CYCLE_W];
  assign out_reg   = rd_entry[REG_LSB +: REG_W];
  assign out_data  = rd_entry[0 +: DATA_W];
  assign count     = ring_count;
  assign overflow  = overflow_q;
  assign dropped   = dropped_q;
  assign done      = done_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Three DEPTH=4 instances (STOP, WRAP, STOP with a 10-cycle window) share one stimulus stream
// and are checked every cycle against a queue-based model, plus directed literal expectations.
module tb_commit_trace_buffer;
  import trace_pkg::*;

  localparam int N     = 3;
  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        wb_enable;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        out_ready;

  logic        out_valid [N];
  logic [31:0] out_cycle [N];
  logic [4:0]  out_reg   [N];
  logic [31:0] out_data  [N];
  logic [2:0]  count     [N];
  logic        overflow  [N];
  logic [15:0] dropped   [N];
  logic        done      [N];

  int total;
  int bad;

  typedef struct {
    int unsigned cyc;
    int unsigned rg;
    int unsigned dat;
  } ent_t;

  ent_t        mq [N][$];
  int unsigned m_cyc  [N];
  bit          m_done [N];
  bit          m_ovf  [N];
  int unsigned m_drop [N];

  commit_trace_buffer #(.DATA_W(32), .REG_W(5), .DEPTH(DEPTH), .CYCLE_W(32),
                        .CYCLE_LIMIT(1000), .MODE(STOP)) dut_stop (
    .clock(clock), .reset(reset), .wb_enable(wb_enable), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_cycle(out_cycle[0]),
    .out_reg(out_reg[0]), .out_data(out_data[0]), .count(count[0]),
    .overflow(overflow[0]), .dropped(dropped[0]), .done(done[0]));

  commit_trace_buffer #(.DATA_W(32), .REG_W(5), .DEPTH(DEPTH), .CYCLE_W(32),
                        .CYCLE_LIMIT(1000), .MODE(WRAP)) dut_wrap (
    .clock(clock), .reset(reset), .wb_enable(wb_enable), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_cycle(out_cycle[1]),
    .out_reg(out_reg[1]), .out_data(out_data[1]), .count(count[1]),
    .overflow(overflow[1]), .dropped(dropped[1]), .done(done[1]));

  commit_trace_buffer #(.DATA_W(32), .REG_W(5), .DEPTH(DEPTH), .CYCLE_W(32),
                        .CYCLE_LIMIT(10), .MODE(STOP)) dut_win (
    .clock(clock), .reset(reset), .wb_enable(wb_enable), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid[2]), .out_ready(out_ready), .out_cycle(out_cycle[2]),
    .out_reg(out_reg[2]), .out_data(out_data[2]), .count(count[2]),
    .overflow(overflow[2]), .dropped(dropped[2]), .done(done[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int unsigned limit_of(input int i);
    return (i == 2) ? 10 : 1000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Queue model: pop first, then the event either fits, is dropped, or evicts the oldest.
  task automatic model_edge(input bit rst, input bit en, input int unsigned rg,
                            input int unsigned dat, input bit rdy);
    ent_t e;
    bit   cap;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        mq[i].delete();
        m_cyc[i]  = 0;
        m_done[i] = 0;
        m_ovf[i]  = 0;
        m_drop[i] = 0;
      end else begin
        cap   = en && (rg != 0) && !m_done[i];
        e.cyc = m_cyc[i];
        e.rg  = rg;
        e.dat = dat;
        if (mq[i].size() != 0 && rdy) void'(mq[i].pop_front());
        if (cap) begin
          if (mq[i].size() < DEPTH) begin
            mq[i].push_back(e);
          end else begin
            m_ovf[i] = 1;
            if (m_drop[i] < 32'hFFFF) m_drop[i]++;
            if (i == 1) begin
              void'(mq[i].pop_front());
              mq[i].push_back(e);
            end
          end
        end
        if (!m_done[i]) begin
          m_cyc[i]++;
          if (m_cyc[i] == limit_of(i)) m_done[i] = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("valid%0d", i), out_valid[i], mq[i].size() != 0);
      chk($sformatf("count%0d", i), count[i], mq[i].size());
      chk($sformatf("ovf%0d", i), overflow[i], m_ovf[i]);
      chk($sformatf("drop%0d", i), dropped[i], m_drop[i]);
      chk($sformatf("done%0d", i), done[i], m_done[i]);
      if (mq[i].size() != 0) begin
        chk($sformatf("cyc%0d", i), out_cycle[i], mq[i][0].cyc);
        chk($sformatf("reg%0d", i), out_reg[i], mq[i][0].rg);
        chk($sformatf("data%0d", i), out_data[i], mq[i][0].dat);
      end
    end
  endtask

  task automatic step(input bit rst, input bit en, input int unsigned rg,
                      input int unsigned dat, input bit rdy);
    reset     = rst;
    wb_enable = en;
    wb_reg    = rg[4:0];
    wb_data   = dat;
    out_ready = rdy;
    @(posedge clock);
    model_edge(rst, en, rg, dat, rdy);
    @(negedge clock);
    compare_all();
  endtask

  initial begin
    int unsigned wrap_exp [4];
    int produced;
    int unsigned last_cyc;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    wb_enable = 1'b0;
    wb_reg    = '0;
    wb_data   = '0;
    out_ready = 1'b0;
    @(negedge clock);

    // Stamped entries, head held while not ready
    step(1, 0, 0, 0, 0);
    chk("rst_valid", out_valid[0], 0);
    chk("rst_count", count[0], 0);
    for (int k = 0; k < 7; k++) begin
      if (k == 3) step(0, 1, 1, 32'h11, 0);
      else if (k == 5) step(0, 1, 2, 32'h22, 0);
      else step(0, 0, 0, 0, 0);
    end
    chk("p1_count", count[0], 2);
    chk("p1_cyc0", out_cycle[0], 3);
    chk("p1_reg0", out_reg[0], 1);
    chk("p1_dat0", out_data[0], 32'h11);
    step(0, 0, 0, 0, 1);
    chk("p1_cyc1", out_cycle[0], 5);
    chk("p1_reg1", out_reg[0], 2);
    chk("p1_dat1", out_data[0], 32'h22);

    // Register 0 is never captured
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 32'hDEAD, 0);
    step(0, 0, 0, 0, 0);
    chk("r0_count", count[0], 0);
    chk("r0_drop", dropped[0], 0);

    // Overflow: STOP keeps the first four, WRAP keeps the last four
    step(1, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) step(0, 1, k, k, 0);
    chk("stop_count", count[0], 4);
    chk("stop_drop", dropped[0], 2);
    chk("stop_ovf", overflow[0], 1);
    chk("stop_head", out_data[0], 1);
    chk("wrap_count", count[1], 4);
    chk("wrap_drop", dropped[1], 2);
    chk("wrap_ovf", overflow[1], 1);
    wrap_exp[0] = 3; wrap_exp[1] = 4; wrap_exp[2] = 5; wrap_exp[3] = 6;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("wrap_ord%0d", j), out_data[1], wrap_exp[j]);
      step(0, 0, 0, 0, 1);
    end
    chk("wrap_empty", out_valid[1], 0);

    // Reset mid-drain abandons entries and clears flags and the cycle counter
    step(1, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) step(0, 1, k, k, 0);
    step(0, 0, 0, 0, 1);
    chk("mid_count", count[0], 3);
    step(1, 1, 9, 32'h99, 1);
    chk("mr_count", count[0], 0);
    chk("mr_valid", out_valid[0], 0);
    chk("mr_ovf", overflow[0], 0);
    chk("mr_drop", dropped[0], 0);
    step(0, 1, 7, 32'h77, 0);
    chk("mr_cyc", out_cycle[0], 0);
    chk("mr_reg", out_reg[0], 7);

    // 10-cycle window with continuous reads
    step(1, 0, 0, 0, 0);
    produced = 0;
    last_cyc = 0;
    for (int k = 0; k < 18; k++) begin
      if (out_valid[2]) begin
        produced++;
        last_cyc = out_cycle[2];
      end
      if (k < 14) step(0, 1, (k % 31) + 1, 32'h100 + k, 1);
      else step(0, 0, 0, 0, 1);
      if (k == 8) chk("win_done8", done[2], 0);
      if (k == 9) chk("win_done9", done[2], 1);
    end
    chk("win_produced", produced, 10);
    chk("win_lastcyc", last_cyc, 9);
    chk("win_count", count[2], 0);

    // Randomized traffic with occasional resets
    for (int r = 0; r < 4; r++) begin
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < 150; k++) begin
        step($urandom_range(0, 99) == 0,
             ($urandom % 10) < 6,
             $urandom_range(0, 3),
             $urandom,
             ($urandom % 10) < ((r % 2 == 0) ? 4 : 8));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32: writeback data width.
REQ-002 SHALL have parameter REG_W, default 5: register index width.
REQ-003 SHALL have parameter DEPTH, default 16: entries; power of two, 2 or more.
REQ-004 SHALL have parameter CYCLE_W, default 32: timestamp/cycle counter width.
REQ-005 SHALL have parameter CYCLE_LIMIT, default 1000: capture window in cycles; 1 or more.
REQ-006 SHALL have parameter MODE, default STOP: STOP drops new events when full; WRAP overwrites the oldest.
REQ-007 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-008 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-009 SHALL have port wb_enable  input  1  writeback register-file write enable.
REQ-010 SHALL have port wb_reg  input  REG_W  writeback destination register.
REQ-011 SHALL have port wb_data  input  DATA_W  writeback data.
REQ-012 SHALL have port out_valid  output  1  head entry available.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the head.
REQ-014 SHALL have ports out_cycle (CYCLE_W), out_reg (REG_W) and out_data (DATA_W)  output: head entry fields.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.
REQ-016 SHALL have port overflow  output  1  sticky flag: an event was lost or overwritten.
REQ-017 SHALL have port dropped  output  16  lost/overwritten events; saturates at 0xFFFF.
REQ-018 SHALL have port done  output  1  capture window expired.

Function
REQ-019 SHALL keep a cycle counter that increments by 1 every cycle while done=0; done SHALL assert on the edge where the counter reaches CYCLE_LIMIT and hold until reset.
REQ-020 SHALL raise a capture event in a cycle only when wb_enable=1, wb_reg!=0 and done=0; writes to register 0 SHALL never be captured.
REQ-021 SHALL store each event as {cycle counter value in that cycle, wb_reg, wb_data}; one-cycle latency, so the entry is visible at the outputs after the next edge.
REQ-022 SHALL drive out_valid=(count!=0); out_* SHALL present the oldest entry and stay stable while out_valid=1 and out_ready=0.
REQ-023 SHALL pop the head on an edge where out_valid=1 and out_ready=1; out_ready is ignored when empty.
REQ-024 SHALL accept push and pop together when not full (count unchanged), and also when full (pop frees the slot; no loss in either mode).
REQ-025 SHALL, in STOP mode, discard an event when full with no pop, set overflow and increment dropped.
REQ-026 SHALL, in WRAP mode, write an event when full with no pop over the oldest entry, advance the read pointer, keep count=DEPTH, set overflow and increment dropped.
REQ-027 SHALL wrap read and write pointers modulo DEPTH.
REQ-028 SHALL continue draining after done=1; capture stays stopped.
REQ-029 SHALL have exactly two states, RUN (done=0) and DONE (done=1); the only transitions are RUN->DONE per REQ-019 and DONE->RUN by reset.

Reset
REQ-030 SHALL, on reset=1 at an edge, clear pointers, count, cycle counter, overflow, dropped and done; out_valid SHALL be 0 the following cycle.
REQ-031 SHALL discard any event present in the reset cycle; reset mid-drain SHALL abandon all stored entries.
REQ-032 SHALL give storage contents no reset value; out_* are don't-care while out_valid=0.

Structure
REQ-033 SHALL define the MODE constants (STOP, WRAP) and the entry field-packing helper in shared package trace_pkg.
REQ-034 SHALL place storage and pointers in one sub-module, trace_ring, with push, pop and overwrite controls; the top level holds the counter, filter, FSM and statistics.

Verification
REQ-035 SHALL check that, with DEPTH=4 and writes r1=0x11 at cycle 3 and r2=0x22 at cycle 5 with out_ready=0, the entries read out are (3,1,0x11) then (5,2,0x22).
REQ-036 SHALL check that wb_enable=1 with wb_reg=0 and data 0xDEAD causes no entry: count stays 0 and dropped stays 0.
REQ-037 SHALL check that in STOP mode with DEPTH=4, 6 events and no reads give count=4, dropped=2, overflow=1, and the head is the first event.
REQ-038 SHALL check that in WRAP mode with DEPTH=4, events with data 1..6 and no reads give count=4, dropped=2, and readout order 3,4,5,6.
REQ-039 SHALL check that with CYCLE_LIMIT=10 and a write every cycle plus continuous reads, done rises after 10 cycles, exactly 10 entries are produced, and later writes are ignored.
REQ-040 SHALL check that reset asserted with count=3 gives count=0, out_valid=0, overflow=0 and cycle counter 0 on the next cycle.
